md_unit: RTL
============

# md_unit

Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core. It generates its own launch pulse from the decoded operation and runs a configurable-latency multiply or divide, holding `busy` until the result commits. It also owns the HI/LO architectural registers and services `mthi`/`mtlo` writes. A `cancel` input lets exception flush abort an in-flight operation without disturbing HI/LO.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width; must be at least 2.
- `MULT_CYCLES`, 5: busy cycles for multiply-class ops; must be at least 1.
- `DIV_CYCLES`, 10: busy cycles for divide ops; must be at least 1.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `op`, input, 4: operation code.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
  - 7 madd, 8 maddu, 9 msub, 10 msubu (only with the macro).
  - Other codes are treated as none.
- `a`, input, WIDTH: rs operand / dividend.
- `b`, input, WIDTH: rt operand / divisor.
- `cancel`, input, 1: exception flush; aborts the in-flight op and suppresses a same-cycle launch.
- `start`, output, 1: combinational launch pulse. Asserted when `op` is multiply/divide class, `busy`=0 and `cancel`=0.
- `busy`, output, 1: registered; 1 while an operation is in flight.
- `hi`, output, WIDTH: registered HI.
- `lo`, output, WIDTH: registered LO.

## Operation
- Reset: `busy`=0, `hi`=0, `lo`=0, cycle counter=0, shadow result=0, state IDLE. Any in-flight op is discarded.
- FSM states: IDLE and RUN.
  - IDLE to RUN on an edge where `start`=1.
  - RUN to IDLE when the counter reaches 1, or on `cancel`.
- At launch:
  - The full result is computed from `a`/`b` and latched into shadow registers.
  - The counter loads `MULT_CYCLES` or `DIV_CYCLES`.
- RUN: the counter decrements each cycle. On the edge where it is 1, shadow HI/LO are copied to `hi`/`lo` and `busy` clears.
- Arithmetic:
  - mult/multu: 2·WIDTH-bit signed or unsigned product; HI = upper half, LO = lower half.
  - div/divu: LO = quotient, truncated toward zero; HI = remainder, sign of the dividend.
  - Signed MIN / -1: LO = MIN, HI = 0.
  - Divide by zero (b=0): the op runs the full `DIV_CYCLES`, then HI/LO are left unchanged.
- mthi/mtlo:
  - Write `hi`/`lo` from `a` on the next edge; no busy period.
  - Accepted only when `busy`=0; ignored while busy.
- A multiply/divide op presented while `busy`=1 is ignored: no start, no state change. The hazard unit stalls it upstream.
- `cancel`:
  - In RUN: returns to IDLE and clears `busy` on the next edge; shadow is discarded and `hi`/`lo` are unchanged.
  - In IDLE: blocks `start` and any mthi/mtlo that cycle.
  - Cancel takes priority over the commit edge: if `cancel`=1 on the edge where the counter is 1, no commit occurs.

## Timing
- Launch on edge k with `start`=1, N = op latency:
  - `busy`=1 after edges k through k+N-1.
  - `busy`=0 and new `hi`/`lo` visible after edge k+N.
- Back-to-back: a new op may launch in the cycle `busy` reads 0, i.e. edge k+N sees `busy`=1, so the earliest new launch is edge k+N+1 with `start`=1.
- mthi/mtlo latency: 1 edge.
- `start` has a purely combinational path from `op`, `busy` and `cancel`.

## Configuration
- `MD_MADD_EN` defined:
  - Ops 7–10 are multiply-class with `MULT_CYCLES` latency.
  - The result is {hi,lo} ± product, modulo 2^(2·WIDTH), using the HI/LO values at launch.
  - Signed ops use a signed product; unsigned ops use an unsigned product.
- Not defined: codes 7–10 decode as none, with no start and no state change.

## Test plan
- Reset mid-run: assert `reset` 2 cycles after a div launch → `busy`=0, `hi`=`lo`=0 next cycle, no later commit.
- mult a=0xFFFFFFFF, b=2 → `start`=1 for 1 cycle, `busy` high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div a=-7, b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000, b=-1 → lo=0x80000000, hi=0. divu b=0 → hi/lo unchanged.
- Issue mthi a=5 while busy → ignored. Issue mult during busy → `start`=0 and the result is from the first op only. mtlo a=9 when idle → lo=9 next cycle.
- `cancel` on the commit edge of a multu → hi/lo keep their prior values, `busy`=0 next cycle. `cancel` together with op=div in IDLE → `start`=0.
- `MD_MADD_EN`, with hi=0, lo=10: madd a=3, b=4 → lo=22. msubu a=1, b=30 → {hi,lo}=0xFFFFFFFF_FFFFFFF8. Without the macro, op=7 → `start`=0.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO ownership, fixed-latency busy period and flush cancel.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MD_MADD_EN.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbg_state
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    state_t state, next_state;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   sh_hi, sh_lo;
    logic               sh_skip;

    logic               is_mul, is_div, mul_signed, div_signed;
    logic [2*WIDTH-1:0] ea, eb, prod, mul_res;
    logic [WIDTH-1:0]   abs_a, abs_b, dvs, q_mag, r_mag, quot, rem;

    // Operation decode; anything unrecognised behaves as none.
    always_comb begin
        is_mul     = (op == OP_MULT) || (op == OP_MULTU);
        mul_signed = (op == OP_MULT);
`ifdef MD_MADD_EN
        if (op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU)
            is_mul = 1'b1;
        if (op == OP_MADD || op == OP_MSUB)
            mul_signed = 1'b1;
`endif
        is_div     = (op == OP_DIV) || (op == OP_DIVU);
        div_signed = (op == OP_DIV);
    end

    assign start     = (is_mul || is_div) && !busy && !cancel;
    assign busy      = (state == RUN);
    assign dbg_state = state;

    // Truncating the product of the extended operands to 2*WIDTH gives the exact product.
    always_comb begin
        ea   = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb   = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod = ea * eb;
        mul_res = prod;
`ifdef MD_MADD_EN
        if (op == OP_MADD || op == OP_MADDU)
            mul_res = {hi, lo} + prod;
        else if (op == OP_MSUB || op == OP_MSUBU)
            mul_res = {hi, lo} - prod;
`endif
    end

    // Sign-magnitude divide; MIN / -1 falls out naturally as quotient MIN, remainder 0.
    always_comb begin
        abs_a = (div_signed && a[WIDTH-1]) ? -a : a;
        abs_b = (div_signed && b[WIDTH-1]) ? -b : b;
        dvs   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
        q_mag = abs_a / dvs;
        r_mag = abs_a % dvs;
        quot  = (div_signed && (a[WIDTH-1] ^ b[WIDTH-1])) ? -q_mag : q_mag;
        rem   = (div_signed && a[WIDTH-1]) ? -r_mag : r_mag;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (cancel || cnt == CNT_ONE) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sh_hi   <= '0;
            sh_lo   <= '0;
            sh_skip <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (start) begin
                    cnt <= is_mul ? MULT_LD : DIV_LD;
                    if (is_mul) begin
                        {sh_hi, sh_lo} <= mul_res;
                        sh_skip        <= 1'b0;
                    end else begin
                        sh_hi   <= rem;
                        sh_lo   <= quot;
                        sh_skip <= (b == '0);
                    end
                end else if (!cancel) begin
                    if (op == OP_MTHI) hi <= a;
                    if (op == OP_MTLO) lo <= a;
                end
            end else begin
                if (cancel) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE && !sh_skip) begin
                        hi <= sh_hi;
                        lo <= sh_lo;
                    end
                end
            end
        end
    end
endmodule
